mem_stage_ws: RTL and testbench

//  Parametrised data-memory pipeline stage with configurable wait states, byte/half/word

---
 rtl/mem_stage_ws.sv | 172 +++++++++++++++++
 tb/tb_mem_stage_ws.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ws.sv
// Data-memory pipeline stage between EXE and WB: byte/half/word loads and stores with
// optional wait states, sign/zero-extended loads, address-error detection and a MEM/WB register.
module mem_stage_ws #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_STATES = 0,
    parameter int          DEST_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [1:0]        mem_size_in,
    input  logic              sign_ext_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [31:0]       alu_result_in,
    input  logic [31:0]       store_data_in,
    output logic              stall,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [31:0]       alu_result_out,
    output logic [31:0]       mem_data_out,
    output logic              addr_err
);

    localparam int          AW    = $clog2(DEPTH);
    localparam int          CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [31:0]   off;
    logic [AW-1:0] word;
    logic [1:0]    lane;
    logic          is_mem, misalign, err, access, complete;

    assign off    = alu_result_in - BASE_ADDR;
    assign word   = off[AW+1:2];
    assign lane   = off[1:0];
    assign is_mem = mem_r_en_in | mem_w_en_in;

    always_comb begin
        misalign = 1'b0;
        case (mem_size_in)
            2'b01:   misalign = lane[0];
            2'b10:   misalign = (lane != 2'b00);
            2'b11:   misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
    end

    assign err    = is_mem & (misalign | (off >= SPAN));
    assign access = is_mem & ~err;

    // ---------------- wait-state FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (WAIT_STATES > 0) begin
            case (state_reg)
                S_IDLE: begin
                    if (access) begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_W'(WAIT_STATES - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
                    else               state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall    = 1'b0;
        complete = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_IDLE: begin
                    if (access) begin
                        if (WAIT_STATES == 0) complete = 1'b1;
                        else                  stall    = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_reg != '0) stall    = 1'b1;
                    else               complete = access;
                end
                default: stall = 1'b0;
            endcase
        end
    end

    // ---------------- data memory ----------------
    // Words are stored XOR'd with their index, so the all-zero power-up image reads back as word i = i.
    logic [31:0] mem_reg [DEPTH];
    logic [31:0] key, rd_word, wdata;
    logic [3:0]  be;

    assign key     = 32'(word);
    assign rd_word = mem_reg[word] ^ key;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign be[gi] = (mem_size_in == 2'b00) ? (lane == 2'(gi)) :
                        (mem_size_in == 2'b01) ? (lane[1] == 1'(gi / 2)) : 1'b1;
        assign wdata[gi*8 +: 8] = (mem_size_in == 2'b00) ? store_data_in[7:0] :
                                  (mem_size_in == 2'b01) ? store_data_in[(gi % 2)*8 +: 8] :
                                                           store_data_in[gi*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (complete && mem_w_en_in) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_reg[word][i*8 +: 8] <= wdata[i*8 +: 8] ^ key[i*8 +: 8];
            end
        end
    end

    // ---------------- load extraction ----------------
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign byte_sel = rd_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        case (mem_size_in)
            2'b00:   load_data = {{24{sign_ext_in & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{sign_ext_in & half_sel[15]}}, half_sel};
            default: load_data = rd_word;
        endcase
    end

    // ---------------- MEM/WB register (bubble while stalled) ----------------
    always_ff @(posedge clk) begin
        if (rst || stall) begin
            wb_en_out      <= 1'b0;
            mem_r_en_out   <= 1'b0;
            dest_out       <= '0;
            alu_result_out <= '0;
            mem_data_out   <= '0;
            addr_err       <= 1'b0;
        end else begin
            wb_en_out      <= wb_en_in & ~err;
            mem_r_en_out   <= mem_r_en_in;
            dest_out       <= dest_in;
            alu_result_out <= alu_result_in;
            mem_data_out   <= (mem_r_en_in && !err) ? load_data : 32'd0;
            addr_err       <= err;
        end
    end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Bench for mem_stage_ws: a single-cycle instance (table + random vs. model) and a 3-wait-state instance.
module tb_mem_stage_ws;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wb, r, w;
        logic [1:0]  size;
        logic        sext;
        logic [4:0]  dest;
        logic [31:0] alu, sd;
    } in_t;

    typedef struct packed {
        logic        wb, r;
        logic [4:0]  dest;
        logic [31:0] alu, data;
        logic        err;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    in_t in0, in3;
    logic stall0, wb0, r0, err0, stall3, wb3, r3, err3;
    logic [4:0]  dest0, dest3;
    logic [31:0] alu0, data0, alu3, data3;
    out_t o0, o3;

    assign o0 = {wb0, r0, dest0, alu0, data0, err0};
    assign o3 = {wb3, r3, dest3, alu3, data3, err3};

    mem_stage_ws #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0), .DEST_W(5)) u0 (
        .clk(clk), .rst(rst),
        .wb_en_in(in0.wb), .mem_r_en_in(in0.r), .mem_w_en_in(in0.w),
        .mem_size_in(in0.size), .sign_ext_in(in0.sext), .dest_in(in0.dest),
        .alu_result_in(in0.alu), .store_data_in(in0.sd),
        .stall(stall0), .wb_en_out(wb0), .mem_r_en_out(r0), .dest_out(dest0),
        .alu_result_out(alu0), .mem_data_out(data0), .addr_err(err0)
    );

    mem_stage_ws #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3), .DEST_W(5)) u3 (
        .clk(clk), .rst(rst),
        .wb_en_in(in3.wb), .mem_r_en_in(in3.r), .mem_w_en_in(in3.w),
        .mem_size_in(in3.size), .sign_ext_in(in3.sext), .dest_in(in3.dest),
        .alu_result_in(in3.alu), .store_data_in(in3.sd),
        .stall(stall3), .wb_en_out(wb3), .mem_r_en_out(r3), .dest_out(dest3),
        .alu_result_out(alu3), .mem_data_out(data3), .addr_err(err3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic in_t mk(input logic wb, input logic r, input logic w, input logic [1:0] size,
                               input logic sext, input logic [4:0] dest, input logic [31:0] alu,
                               input logic [31:0] sd);
        in_t x;
        x.wb = wb; x.r = r; x.w = w; x.size = size; x.sext = sext;
        x.dest = dest; x.alu = alu; x.sd = sd;
        return x;
    endfunction

    function automatic out_t ex(input logic wb, input logic r, input logic [4:0] dest,
                                input logic [31:0] alu, input logic [31:0] data, input logic err);
        out_t x;
        x.wb = wb; x.r = r; x.dest = dest; x.alu = alu; x.data = data; x.err = err;
        return x;
    endfunction

    // Reference model of the single-cycle instance's memory, as a plain array of words.
    logic [31:0] mdl [DEPTH];

    function automatic out_t model(input in_t v);
        out_t        o;
        logic [31:0] off, val, mask;
        int          n, idx, lane;
        bit          bad;
        off  = v.alu - BASE;
        n    = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        bad  = (v.r || v.w) && (v.size == 2'd3 || off >= 32'(4 * DEPTH) || (off % 32'(n)) != 0);
        o    = '0;
        o.wb   = v.wb && !bad;
        o.r    = v.r;
        o.dest = v.dest;
        o.alu  = v.alu;
        o.err  = bad;
        if ((v.r || v.w) && !bad) begin
            idx  = int'(off / 32'd4);
            lane = int'(off % 32'd4);
            if (v.r) begin
                mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
                val  = (mdl[idx] >> (8 * lane)) & mask;
                if (v.sext && val[8*n-1]) val = val | ~mask;
                o.data = val;
            end
            if (v.w) begin
                for (int b = 0; b < n; b++) mdl[idx][8*(lane+b) +: 8] = v.sd[8*b +: 8];
            end
        end
        return o;
    endfunction

    // One single-cycle transaction on u0: stall must stay low, registered outputs checked after the edge.
    task automatic step0(input string nm, input in_t v, input out_t exp);
        @(negedge clk);
        in0 = v;
        #1;
        chk({nm, " stall"}, 80'(stall0), 80'(0));
        @(posedge clk);
        #1;
        chk(nm, 80'(o0), 80'(exp));
        $display("txn u0 %-10s r=%0b w=%0b sz=%0d alu=%h -> data=%h err=%0b",
                 nm, v.r, v.w, v.size, v.alu, data0, err0);
    endtask

    // One in-range access on u3: exactly three stalled cycles with bubbles, then completion.
    task automatic ws3_access(input string nm, input in_t v, input out_t exp);
        @(negedge clk);
        in3 = v;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("%s stall%0d", nm, k), 80'(stall3), 80'(1));
            @(posedge clk);
            #1;
            chk($sformatf("%s bubble%0d", nm, k), 80'(o3), 80'(0));
            @(negedge clk);
        end
        #1;
        chk({nm, " release"}, 80'(stall3), 80'(0));
        @(posedge clk);
        #1;
        chk(nm, 80'(o3), 80'(exp));
        $display("txn u3 %-10s r=%0b w=%0b alu=%h -> data=%h err=%0b",
                 nm, v.r, v.w, v.alu, data3, err3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        in_t  v;
        out_t e;

        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'(i);
        in0 = '0;
        in3 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset u0", 80'({stall0, o0}), 80'(0));
        chk("reset u3", 80'({stall3, o3}), 80'(0));
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table-driven single-cycle vectors ----------------
        tbl.push_back('{"st_word",  mk(0,0,1,2'd2,0,5'd1,32'h400,32'hDEADBEEF), ex(0,0,5'd1,32'h400,32'h0,0)});
        tbl.push_back('{"ld_word",  mk(1,1,0,2'd2,0,5'd2,32'h400,32'h0),        ex(1,1,5'd2,32'h400,32'hDEADBEEF,0)});
        tbl.push_back('{"st_byte",  mk(0,0,1,2'd0,0,5'd1,32'h401,32'h12345680), ex(0,0,5'd1,32'h401,32'h0,0)});
        tbl.push_back('{"ld_byte_s",mk(1,1,0,2'd0,1,5'd3,32'h401,32'h0),        ex(1,1,5'd3,32'h401,32'hFFFFFF80,0)});
        tbl.push_back('{"ld_byte_z",mk(1,1,0,2'd0,0,5'd3,32'h401,32'h0),        ex(1,1,5'd3,32'h401,32'h00000080,0)});
        tbl.push_back('{"ld_word2", mk(1,1,0,2'd2,0,5'd4,32'h400,32'h0),        ex(1,1,5'd4,32'h400,32'hDEAD80EF,0)});
        tbl.push_back('{"ld_half_s",mk(1,1,0,2'd1,1,5'd4,32'h402,32'h0),        ex(1,1,5'd4,32'h402,32'hFFFFDEAD,0)});
        tbl.push_back('{"err_low",  mk(1,1,0,2'd2,0,5'd5,32'h3FC,32'h0),        ex(0,1,5'd5,32'h3FC,32'h0,1)});
        tbl.push_back('{"err_high", mk(1,1,0,2'd2,0,5'd5,32'h1400,32'h0),       ex(0,1,5'd5,32'h1400,32'h0,1)});
        tbl.push_back('{"top_word", mk(1,1,0,2'd2,0,5'd6,32'h13FC,32'h0),       ex(1,1,5'd6,32'h13FC,32'h3FF,0)});
        tbl.push_back('{"err_half", mk(1,1,0,2'd1,0,5'd6,32'h401,32'h0),        ex(0,1,5'd6,32'h401,32'h0,1)});
        tbl.push_back('{"err_size3",mk(1,0,1,2'd3,0,5'd8,32'h404,32'hFFFFFFFF), ex(0,0,5'd8,32'h404,32'h0,1)});
        tbl.push_back('{"ld_404",   mk(1,1,0,2'd2,0,5'd8,32'h404,32'h0),        ex(1,1,5'd8,32'h404,32'h1,0)});
        tbl.push_back('{"err_stmis",mk(1,0,1,2'd2,0,5'd9,32'h40A,32'h11111111), ex(0,0,5'd9,32'h40A,32'h0,1)});
        tbl.push_back('{"ld_408",   mk(1,1,0,2'd2,0,5'd9,32'h408,32'h0),        ex(1,1,5'd9,32'h408,32'h2,0)});
        tbl.push_back('{"rw_same",  mk(1,1,1,2'd2,0,5'd10,32'h408,32'hCAFEF00D),ex(1,1,5'd10,32'h408,32'h2,0)});
        tbl.push_back('{"ld_rw",    mk(1,1,0,2'd2,0,5'd10,32'h408,32'h0),       ex(1,1,5'd10,32'h408,32'hCAFEF00D,0)});
        tbl.push_back('{"st_half",  mk(0,0,1,2'd1,0,5'd11,32'h40E,32'h7777BEEF),ex(0,0,5'd11,32'h40E,32'h0,0)});
        tbl.push_back('{"ld_40c",   mk(1,1,0,2'd2,0,5'd11,32'h40C,32'h0),       ex(1,1,5'd11,32'h40C,32'hBEEF0003,0)});
        tbl.push_back('{"nonmem",   mk(1,0,0,2'd0,0,5'd7,32'h55,32'h0),         ex(1,0,5'd7,32'h55,32'h0,0)});

        foreach (tbl[i]) begin
            e = model(tbl[i].in);
            step0(tbl[i].name, tbl[i].in, tbl[i].exp);
        end

        // ---------------- randomized vs. reference model ----------------
        for (int t = 0; t < 200; t++) begin
            v.wb   = 1'($urandom_range(0, 1));
            v.r    = 1'($urandom_range(0, 1));
            v.w    = 1'($urandom_range(0, 1));
            v.size = 2'($urandom_range(0, 3));
            v.sext = 1'($urandom_range(0, 1));
            v.dest = 5'($urandom);
            v.sd   = $urandom;
            if ($urandom_range(0, 1) == 0) v.alu = BASE + 32'($urandom_range(0, 63));
            else                           v.alu = BASE - 32'd16 + 32'($urandom_range(0, 4 * DEPTH + 32));
            e = model(v);
            step0($sformatf("rnd%0d", t), v, e);
        end
        @(negedge clk);
        in0 = '0;

        // ---------------- three wait states ----------------
        ws3_access("ws3_ld404", mk(1,1,0,2'd2,0,5'd4,32'h404,32'h0), ex(1,1,5'd4,32'h404,32'h1,0));
        ws3_access("ws3_b2b",   mk(1,1,0,2'd2,0,5'd5,32'h408,32'h0), ex(1,1,5'd5,32'h408,32'h2,0));

        @(negedge clk);
        in3 = mk(1,1,0,2'd2,0,5'd6,32'h3FC,32'h0);
        #1;
        chk("ws3_err stall", 80'(stall3), 80'(0));
        @(posedge clk);
        #1;
        chk("ws3_err", 80'(o3), 80'(ex(0,1,5'd6,32'h3FC,32'h0,1)));

        @(negedge clk);
        in3 = mk(1,0,0,2'd0,0,5'd7,32'h55,32'h0);
        #1;
        chk("ws3_nonmem stall", 80'(stall3), 80'(0));
        @(posedge clk);
        #1;
        chk("ws3_nonmem", 80'(o3), 80'(ex(1,0,5'd7,32'h55,32'h0,0)));

        // Reset lands on the second cycle of a pending store.
        @(negedge clk);
        in3 = mk(0,0,1,2'd2,0,5'd8,32'h408,32'h12345678);
        #1;
        chk("ws3_rst stall", 80'(stall3), 80'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ws3_rst stall_in_rst", 80'(stall3), 80'(0));
        @(posedge clk);
        #1;
        chk("ws3_rst outputs", 80'(o3), 80'(0));
        @(negedge clk);
        rst = 1'b0;
        in3 = '0;
        #1;
        chk("ws3_rst idle", 80'(stall3), 80'(0));
        ws3_access("ws3_post_rst", mk(1,1,0,2'd2,0,5'd9,32'h408,32'h0), ex(1,1,5'd9,32'h408,32'h2,0));

        ws3_access("ws3_st40c", mk(0,0,1,2'd2,0,5'd10,32'h40C,32'hA5A5A5A5), ex(0,0,5'd10,32'h40C,32'h0,0));
        ws3_access("ws3_ld40c", mk(1,1,0,2'd2,0,5'd10,32'h40C,32'h0),        ex(1,1,5'd10,32'h40C,32'hA5A5A5A5,0));

        @(negedge clk);
        in3 = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
